// File: rtl/data_mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_rmw_ctrl
// Description : Data-memory access sequencer between the store/load
//               result-routing stage and a req/gnt/rvalid bus.
//               Loads issue one word read. Stores issue a read, wait one
//               MERGE cycle while the routing stage folds the returned word
//               into wdata_i, then write the merged word. The pipeline is
//               stalled until the access completes. A read that never
//               returns is ended by a watchdog that pulses err_o.
// Optional    : DMEM_SW_BYPASS_EN - full-word stores (SW) skip the read and
//               MERGE phases and go straight to the bus write.
// Ports       : clk, rst_n              clock, async active-low reset
//               req_i/wr_en_i/funct3_i  access request, store flag, size
//               addr_i/wdata_i          byte address, merged store word
//               rdata_o                 captured bus read word
//               stall_o                 pipeline hold (combinational)
//               err_o                   one-cycle read-timeout pulse
//               bus_req_o/bus_we_o      bus request / write enable
//               bus_addr_o/bus_wdata_o  word-aligned address / write data
//               bus_gnt_i/bus_rvalid_i  grant / read-data valid
//               bus_rdata_i             bus read data
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef INST_SW
`define INST_SW 3'b010
`endif

module data_mem_rmw_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  wr_en_i,
    input  logic [2:0]            funct3_i,
    input  logic [`CPU_WIDTH-1:0] addr_i,
    input  logic [`CPU_WIDTH-1:0] wdata_i,
    output logic [`CPU_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [`CPU_WIDTH-1:0] bus_addr_o,
    output logic [`CPU_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [`CPU_WIDTH-1:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_MERGE   = 3'd3,
        S_WR_REQ  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_we_q;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       w_timeout;
    logic       w_bypass;

    // Byte-lane bits of the address and the size code only matter to the
    // routing stage (and to the SW bypass when it is built in).
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, addr_i[1:0], funct3_i};

`ifdef DMEM_SW_BYPASS_EN
    assign w_bypass = wr_en_i && (funct3_i == `INST_SW);
`else
    assign w_bypass = 1'b0;
`endif

    // Saturating wait counter; the watchdog fires when the counter would
    // reach TIMEOUT_CYCLES-1, so the error pulse lands TIMEOUT_CYCLES
    // cycles after the read grant.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc >= C_CNT_LAST);

    assign stall_o = ((r_state == S_IDLE) && req_i) ||
                     ((r_state != S_IDLE) && (r_state != S_DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_state_next = w_bypass ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (bus_gnt_i) begin
                    w_state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus_rvalid_i) begin
                    w_state_next = r_we_q ? S_MERGE : S_DONE;
                end else if (w_timeout) begin
                    // A store whose read times out is dropped here.
                    w_state_next = S_DONE;
                end
            end
            S_MERGE:  w_state_next = S_WR_REQ;
            S_WR_REQ: begin
                if (bus_gnt_i) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we_q      <= 1'b0;
            r_cnt       <= 8'd0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            r_state   <= w_state_next;
            err_o     <= 1'b0;
            // Request/write-enable follow the next state so they rise on
            // entry to a request state and hold until the grant.
            bus_req_o <= (w_state_next == S_RD_REQ) || (w_state_next == S_WR_REQ);
            bus_we_o  <= (w_state_next == S_WR_REQ);
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        bus_addr_o <= {addr_i[`CPU_WIDTH-1:2], 2'b00};
                        r_we_q     <= wr_en_i;
                        if (w_bypass) begin
                            bus_wdata_o <= wdata_i;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus_gnt_i) begin
                        r_cnt <= 8'd0;
                    end
                end
                S_RD_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (bus_rvalid_i) begin
                        rdata_o <= bus_rdata_i;
                    end else if (w_timeout) begin
                        rdata_o <= '0;
                        err_o   <= 1'b1;
                    end
                end
                S_MERGE: begin
                    // rdata_o has been stable for a cycle, so wdata_i now
                    // carries the routing stage's merged word.
                    bus_wdata_o <= wdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_rmw_ctrl
// Description : Scoreboard bench for data_mem_rmw_ctrl. Stimulus pushes the
//               expected bus transactions and completions; a monitor pops
//               and compares them as the DUT presents them. A small bus
//               slave answers grants/reads, and the routing-stage merge of
//               sub-word stores is modelled on wdata_i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_rmw_ctrl;

    localparam logic [2:0] F_B = 3'b000;
    localparam logic [2:0] F_H = 3'b001;
    localparam logic [2:0] F_W = 3'b010;

    logic        clk, rst_n, req_i, wr_en_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i, rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        stall_o, err_o, bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;

    data_mem_rmw_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_en_i(wr_en_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic chk_rdata; logic [31:0] rdata; logic err; int stall; } done_exp_t;

    bus_exp_t  exp_bus[$];
    done_exp_t exp_done[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        err_seen = 0;

    logic [31:0] mem [logic [31:0]];
    int          gnt_delay = 0;
    int          rv_delay  = 1;
    bit          rv_en     = 1'b1;
    logic [31:0] st_data   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Routing-stage merge: sub-word store data folded into the read word.
    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] sd, input logic [31:0] old);
        logic [31:0] r;
        r = old;
        case (f3)
            F_B:     r[int'(off)*8 +: 8]     = sd[7:0];
            F_H:     r[int'(off[1])*16 +: 16] = sd[15:0];
            default: r = sd;
        endcase
        return r;
    endfunction

    assign wdata_i = merge(funct3_i, addr_i[1:0], st_data, rdata_o);

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Bus slave: grant after gnt_delay cycles of request, read data
    // rv_delay cycles after acceptance (continues even across a reset).
    initial begin
        int          req_age;
        bit          rd_pending;
        int          rd_wait;
        logic [31:0] rd_addr;
        req_age = 0; rd_pending = 0; rd_wait = 0; rd_addr = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_req_o && bus_gnt_i) begin
                if (bus_we_o) mem[bus_addr_o] = bus_wdata_o;
                else if (rv_en) begin
                    rd_pending = 1; rd_wait = rv_delay; rd_addr = bus_addr_o;
                end
            end
            @(posedge clk); #1;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = 32'hBAD0BAD0;
            if (rd_pending) begin
                rd_wait--;
                if (rd_wait <= 0) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = mem_rd(rd_addr);
                    rd_pending   = 0;
                end
            end
            if (bus_req_o) begin
                bus_gnt_i = (req_age >= gnt_delay);
                req_age++;
            end else begin
                bus_gnt_i = 1'b0;
                req_age   = 0;
            end
        end
    end

    // Monitor: bus transactions, request stability, and completions.
    initial begin
        int          stall_cnt;
        bit          prev_hold;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        bus_exp_t    be;
        done_exp_t   de;
        stall_cnt = 0; prev_hold = 0; p_addr = '0; p_wdata = '0; p_we = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    chk("hold_req",   {31'b0, bus_req_o}, 32'd1);
                    chk("hold_addr",  bus_addr_o, p_addr);
                    chk("hold_we",    {31'b0, bus_we_o}, {31'b0, p_we});
                    chk("hold_wdata", bus_wdata_o, p_wdata);
                end
                prev_hold = bus_req_o && !bus_gnt_i;
                p_addr = bus_addr_o; p_we = bus_we_o; p_wdata = bus_wdata_o;
                if (bus_req_o && bus_gnt_i) begin
                    if (exp_bus.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL bus_unexpected: got we=%b addr=%h expected none", bus_we_o, bus_addr_o);
                    end else begin
                        be = exp_bus.pop_front();
                        chk("bus_we",   {31'b0, bus_we_o}, {31'b0, be.we});
                        chk("bus_addr", bus_addr_o, be.addr);
                        if (be.we) chk("bus_wdata", bus_wdata_o, be.wdata);
                    end
                end
                if (err_o) err_seen++;
                if (stall_o) stall_cnt++;
                else if (stall_cnt != 0) begin
                    if (exp_done.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL done_unexpected: got completion expected none");
                    end else begin
                        de = exp_done.pop_front();
                        if (de.chk_rdata) chk("done_rdata", rdata_o, de.rdata);
                        chk("done_err",   {31'b0, err_o}, {31'b0, de.err});
                        chk("done_stall", stall_cnt, de.stall);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic exp_rd(input logic [31:0] a);
        exp_bus.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    endtask
    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    endtask
    task automatic exp_dn(input logic c, input logic [31:0] d, input logic e, input int s);
        exp_done.push_back('{chk_rdata: c, rdata: d, err: e, stall: s});
    endtask

    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
        int cyc;
        @(posedge clk); #1;
        req_i = 1'b1; wr_en_i = we; funct3_i = f3; addr_i = a; st_data = sd;
        cyc = 0;
        @(negedge clk);
        while (stall_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout: got stall stuck expected completion addr=%h", a);
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_watchdog: got no end expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_i = 1'b0; wr_en_i = 1'b0; funct3_i = F_W; addr_i = '0;
        mem[32'h104] = 32'hDEADBEEF;
        mem[32'h100] = 32'h11223344;
        mem[32'h300] = 32'hCAFEF00D;
        mem[32'h10C] = 32'h0BADF00D;
        mem[32'h110] = 32'h55667788;
        mem[32'h120] = 32'h12121212;
        mem[32'h200] = 32'h01020304;

        // Reset state
        #22;
        chk("rst_rdata",   rdata_o, 32'h0);
        chk("rst_err",     {31'b0, err_o}, 32'h0);
        chk("rst_bus_req", {31'b0, bus_req_o}, 32'h0);
        chk("rst_bus_we",  {31'b0, bus_we_o}, 32'h0);
        chk("rst_addr",    bus_addr_o, 32'h0);
        chk("rst_wdata",   bus_wdata_o, 32'h0);
        chk("rst_stall",   {31'b0, stall_o}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. LW 0x104
        exp_rd(32'h104); exp_dn(1, 32'hDEADBEEF, 0, 3);
        access(1'b0, F_W, 32'h104, 32'h0);

        // 2. SB 0x103 of 0xAA onto 0x11223344
        exp_rd(32'h100); exp_wr(32'h100, 32'hAA223344); exp_dn(1, 32'h11223344, 0, 5);
        access(1'b1, F_B, 32'h103, 32'h000000AA);
        chk("mem_sb", mem_rd(32'h100), 32'hAA223344);

        // 3. SH 0x302 with grant held off 4 cycles in both phases
        gnt_delay = 4;
        exp_rd(32'h300); exp_wr(32'h300, 32'h1234F00D); exp_dn(1, 32'hCAFEF00D, 0, 13);
        access(1'b1, F_H, 32'h302, 32'h00001234);
        exp_rd(32'h104); exp_dn(1, 32'hDEADBEEF, 0, 7);
        access(1'b0, F_W, 32'h104, 32'h0);
        gnt_delay = 0;

        // 4. Read timeouts: load, then a store that must be dropped
        rv_en = 1'b0;
        exp_rd(32'h10C); exp_dn(1, 32'h0, 1, 17);
        access(1'b0, F_W, 32'h10C, 32'h0);
        exp_rd(32'h110); exp_dn(1, 32'h0, 1, 17);
        access(1'b1, F_B, 32'h111, 32'h00000077);
        chk("mem_dropped", mem_rd(32'h110), 32'h55667788);
        rv_en = 1'b1;

        // Reload a known word so the reset below clears a nonzero rdata_o
        exp_rd(32'h104); exp_dn(1, 32'hDEADBEEF, 0, 3);
        access(1'b0, F_W, 32'h104, 32'h0);

        // 5. Reset during RD_WAIT, then a late rvalid
        rv_delay = 5;
        exp_rd(32'h120);
        @(posedge clk); #1;
        req_i = 1'b1; wr_en_i = 1'b0; funct3_i = F_W; addr_i = 32'h120;
        @(posedge clk); #1;          // RD_REQ, granted
        @(posedge clk); #3;          // RD_WAIT
        rst_n = 1'b0; req_i = 1'b0;
        #1;
        chk("arst_rdata",   rdata_o, 32'h0);
        chk("arst_bus_req", {31'b0, bus_req_o}, 32'h0);
        chk("arst_addr",    bus_addr_o, 32'h0);
        chk("arst_wdata",   bus_wdata_o, 32'h0);
        chk("arst_stall",   {31'b0, stall_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("late_rv_rdata", rdata_o, 32'h0);
        chk("late_rv_stall", {31'b0, stall_o}, 32'h0);
        chk("late_rv_req",   {31'b0, bus_req_o}, 32'h0);
        rv_delay = 1;
        exp_rd(32'h104); exp_dn(1, 32'hDEADBEEF, 0, 3);
        access(1'b0, F_W, 32'h104, 32'h0);

        // 6. SW 0x200 with 0x5555AAAA
`ifdef DMEM_SW_BYPASS_EN
        exp_wr(32'h200, 32'h5555AAAA); exp_dn(0, 32'h0, 0, 2);
`else
        exp_rd(32'h200); exp_wr(32'h200, 32'h5555AAAA); exp_dn(1, 32'h01020304, 0, 5);
`endif
        access(1'b1, F_W, 32'h200, 32'h5555AAAA);
        chk("mem_sw", mem_rd(32'h200), 32'h5555AAAA);

        repeat (4) @(negedge clk);
        chk("bus_queue_left",  exp_bus.size(), 32'd0);
        chk("done_queue_left", exp_done.size(), 32'd0);
        chk("err_pulses",      err_seen, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
